// File: rtl/led_pattern_gen_pkg.sv
// Shared types for the multi-channel LED pattern generator.
// Channel mode encoding and config field widths.
package led_pattern_pkg;

  localparam int CH_IDX_W = 4;
  localparam int MODE_W   = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

endpackage

// File: rtl/led_pattern_gen_if.sv
// Config write port: valid/ready request with channel, mode,
// period and duty; cfg_err pulses on a rejected/ignored write.
interface led_pattern_gen_if #(
  parameter int CNT_W = 25
);
  import led_pattern_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_IDX_W-1:0] cfg_ch;
  logic [MODE_W-1:0]   cfg_mode;
  logic [CNT_W-1:0]    cfg_period;
  logic [CNT_W-1:0]    cfg_duty;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode,
    output cfg_period, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode,
    input  cfg_period, cfg_duty,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/led_pattern_gen_ch.sv
// One LED channel: period/duty counter, mode, optional breathe.
// Ports: clk, rst, i_tick, i_clr, i_run, i_load, i_mode,
// i_period, i_duty, o_led. Breathe: LED_PATTERN_BREATHE_EN.
module led_pattern_ch
  import led_pattern_pkg::*;
#(
  parameter int CNT_W        = 25,
  parameter int DEF_PERIOD   = 2**24
`ifdef LED_PATTERN_BREATHE_EN
  ,
  parameter int BREATHE_STEP = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic             i_load,
  input  mode_t            i_mode,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_led
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEF_PERIOD >> 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_duty;
  mode_t            r_mode;
  logic             r_led;

  logic [CNT_W-1:0] w_last;
  logic             w_wrap;

  // period 0 behaves like period 1
  assign w_last = (r_period == '0) ? '0 : r_period - ONE;
  assign w_wrap = r_cnt >= w_last;

`ifdef LED_PATTERN_BREATHE_EN
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(BREATHE_STEP);

  logic             r_up;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_bduty;
  logic             w_bup;

  assign w_sum = {1'b0, r_duty} + STEP;

  // next breathe duty, clamped to [0, period]
  always_comb begin
    w_bduty = r_duty;
    w_bup   = r_up;
    if (r_up) begin
      if (w_sum >= {1'b0, r_period}) begin
        w_bduty = r_period;
        w_bup   = 1'b0;
      end else begin
        w_bduty = w_sum[CNT_W-1:0];
      end
    end else begin
      if ({1'b0, r_duty} <= STEP) begin
        w_bduty = '0;
        w_bup   = 1'b1;
      end else begin
        w_bduty = r_duty - STEP[CNT_W-1:0];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mode   <= MODE_PWM;
      r_period <= DEF_P;
      r_duty   <= DEF_D;
`ifdef LED_PATTERN_BREATHE_EN
      r_up     <= 1'b1;
`endif
    end else if (i_load) begin
      r_cnt    <= '0;
      r_mode   <= i_mode;
      r_period <= i_period;
`ifdef LED_PATTERN_BREATHE_EN
      r_up     <= 1'b1;
      r_duty   <= (i_mode == MODE_BREATHE) ? '0 : i_duty;
`else
      r_duty   <= i_duty;
`endif
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_wrap ? '0 : r_cnt + ONE;
`ifdef LED_PATTERN_BREATHE_EN
      if (w_wrap && r_mode == MODE_BREATHE) begin
        r_duty <= w_bduty;
        r_up   <= w_bup;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_led <= 1'b0;
    end else begin
      unique case (r_mode)
        MODE_OFF: r_led <= 1'b0;
        MODE_ON:  r_led <= 1'b1;
        default:  r_led <= r_cnt < r_duty;
      endcase
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaler, config decode.
// Ports: clk, rst, run, sync, cfg (slave), led[NUM_CH].
// Macro LED_PATTERN_BREATHE_EN enables mode 3 (BREATHE).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_CH       = 7,
  parameter int CNT_W        = 25,
  parameter int PRESCALE     = 1,
  parameter int DEF_PERIOD   = 2**24
`ifdef LED_PATTERN_BREATHE_EN
  ,
  parameter int BREATHE_STEP = 1
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              sync,
  led_pattern_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] led
);

  localparam logic [CH_IDX_W:0] NCH = (CH_IDX_W+1)'(NUM_CH);

  logic  r_ready;
  logic  r_err;
  logic  w_tick;
  logic  w_clr;
  logic  w_acc;
  logic  w_bad_ch;
  logic  w_mode_ill;
  mode_t w_mode;

  assign w_clr    = sync || !run;
  assign w_acc    = cfg.cfg_valid && r_ready;
  assign w_bad_ch = {1'b0, cfg.cfg_ch} >= NCH;

`ifdef LED_PATTERN_BREATHE_EN
  assign w_mode_ill = 1'b0;
`else
  assign w_mode_ill = cfg.cfg_mode == MODE_BREATHE;
`endif

  // an unsupported mode parks the channel dark
  assign w_mode = w_mode_ill ? MODE_OFF : mode_t'(cfg.cfg_mode);

  generate
    if (PRESCALE == 1) begin : g_nopre
      assign w_tick = 1'b1;
    end else begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] r_pre;

      always_ff @(posedge clk) begin
        if (rst || w_clr) begin
          r_pre <= '0;
        end else begin
          r_pre <= (r_pre == LAST) ? '0 : r_pre + PW'(1);
        end
      end

      assign w_tick = r_pre == LAST;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_acc && (w_bad_ch || w_mode_ill);
    end
  end

  assign cfg.cfg_ready = r_ready;
  assign cfg.cfg_err   = r_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic w_load;
      assign w_load = w_acc && (cfg.cfg_ch == CH_IDX_W'(gi));

      led_pattern_ch #(
        .CNT_W       (CNT_W),
        .DEF_PERIOD  (DEF_PERIOD)
`ifdef LED_PATTERN_BREATHE_EN
        ,
        .BREATHE_STEP(BREATHE_STEP)
`endif
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_tick  (w_tick),
        .i_clr   (w_clr),
        .i_run   (run),
        .i_load  (w_load),
        .i_mode  (w_mode),
        .i_period(cfg.cfg_period),
        .i_duty  (cfg.cfg_duty),
        .o_led   (led[gi])
      );
    end
  endgenerate

endmodule
